// File: rtl/jt900h_regdump.sv
// jt900h_regdump: streams a window of the register-file dump port to a byte sink
//
// Optional feature: define JT900H_DUMP_CHKSUM_EN to append a two's-complement
// checksum byte so that every byte of the stream sums to zero mod 256.
//
// Ports:
//   rst       async active-high reset
//   clk       clock
//   start     begin a dump (only looked at in IDLE)
//   abort     cancel the dump in progress, no done pulse
//   busy      high from the start edge until FIN exits
//   done      single-cycle pulse in FIN
//   dmp_addr  address to the dump port (always equals ptr)
//   dmp_din   dump data, registered at the source, one cycle behind dmp_addr
//   tx_data   byte to the sink
//   tx_valid  tx_data valid
//   tx_ready  sink ready; a byte moves when tx_valid and tx_ready meet at a clk edge
module jt900h_regdump #(
    parameter logic [7:0] START = 8'h00,
    parameter logic [7:0] LAST  = 8'h4F
) (
    input  logic       rst,
    input  logic       clk,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [7:0] dmp_addr,
    input  logic [7:0] dmp_din,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

`ifdef JT900H_DUMP_CHKSUM_EN
    typedef enum logic [2:0] {IDLE, WAIT, CAP, SEND, FIN, CHK} state_t;
`else
    typedef enum logic [2:0] {IDLE, WAIT, CAP, SEND, FIN} state_t;
`endif

    state_t     st, st_n;
    logic [7:0] ptr, ptr_n;
    logic [7:0] data_n;
    logic       valid_n, busy_n, hs;
`ifdef JT900H_DUMP_CHKSUM_EN
    logic [7:0] sum, sum_n, sum_add;
`endif

    assign dmp_addr = ptr;
    assign hs       = tx_valid && tx_ready;
    // abort also suppresses the pulse if it lands on the FIN cycle
    assign done     = st == FIN && !abort;
`ifdef JT900H_DUMP_CHKSUM_EN
    assign sum_add  = sum + tx_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            ptr      <= START;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
`ifdef JT900H_DUMP_CHKSUM_EN
            sum      <= 8'h00;
`endif
        end else begin
            st       <= st_n;
            ptr      <= ptr_n;
            tx_data  <= data_n;
            tx_valid <= valid_n;
            busy     <= busy_n;
`ifdef JT900H_DUMP_CHKSUM_EN
            sum      <= sum_n;
`endif
        end
    end

    always_comb begin
        st_n    = st;
        ptr_n   = ptr;
        data_n  = tx_data;
        valid_n = tx_valid;
        busy_n  = busy;
`ifdef JT900H_DUMP_CHKSUM_EN
        sum_n   = sum;
`endif
        case (st)
            IDLE: if (start && !abort) begin
                st_n   = WAIT;
                ptr_n  = START;
                busy_n = 1'b1;
`ifdef JT900H_DUMP_CHKSUM_EN
                sum_n  = 8'h00;
`endif
            end
            // dmp_din for the new ptr only appears after this cycle
            WAIT: st_n = CAP;
            CAP: begin
                data_n  = dmp_din;
                valid_n = 1'b1;
                st_n    = SEND;
            end
            SEND: if (hs) begin
                valid_n = 1'b0;
`ifdef JT900H_DUMP_CHKSUM_EN
                sum_n   = sum_add;
`endif
                if (ptr == LAST) begin
`ifdef JT900H_DUMP_CHKSUM_EN
                    // sum_add already includes the byte accepted on this edge
                    st_n    = CHK;
                    data_n  = 8'h00 - sum_add;
                    valid_n = 1'b1;
`else
                    st_n    = FIN;
`endif
                end else begin
                    ptr_n = ptr + 8'd1;
                    st_n  = WAIT;
                end
            end
`ifdef JT900H_DUMP_CHKSUM_EN
            CHK: if (hs) begin
                valid_n = 1'b0;
                st_n    = FIN;
            end
`endif
            FIN: begin
                busy_n = 1'b0;
                ptr_n  = START;
                st_n   = IDLE;
            end
            default: st_n = IDLE;
        endcase
        if (abort && st != IDLE) begin
            st_n    = IDLE;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            ptr_n   = START;
        end
`ifdef JT900H_DUMP_CHKSUM_EN
        if (abort)
            sum_n = 8'h00;
`endif
    end

endmodule

// File: doc/jt900h_regdump.md
Name: jt900h_regdump

Overview:
Reader for the register-file status-dump port. On a start pulse it sweeps dmp_addr across a configurable address window and absorbs the port's one-cycle registered read latency. It streams each register byte to a byte sink over a valid/ready handshake. It sits between the CPU register file and a debug/simulation byte transport (UART bridge or test harness).

Parameters:
START, 8'h00, first dump address (0x00-0x3F = accumulator bank bytes, 0x40-0x4F = pointer bytes)
LAST, 8'h4F, last dump address, inclusive

Ports:
rst  input  1  asynchronous reset, active-high
clk  input  1  clock
start  input  1  begin a dump; sampled only in IDLE
abort  input  1  terminate the current dump
busy  output  1  high from the start edge until the FIN state exits
done  output  1  one-cycle pulse after the last byte is accepted
dmp_addr  output  8  address to the register-file dump port
dmp_din  input  8  dump data; registered at the source, valid one clk after dmp_addr
tx_data  output  8  byte to sink
tx_valid  output  1  tx_data valid
tx_ready  input  1  sink accepts tx_data when tx_valid and tx_ready are both high at a clk edge

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. No clock enable: the dump port is not cen-gated.
- Reset values: state=IDLE, ptr=START, dmp_addr=START, tx_data=0, tx_valid=0, busy=0, done=0. Checksum accumulator=0 when the feature is compiled in.
- dmp_addr = ptr at all times. ptr is a registered 8-bit value.
- States: IDLE, WAIT, CAP, SEND, FIN; CHK is an additional state when the optional feature is compiled in.
- IDLE: on start=1, ptr<=START, busy<=1, go to WAIT.
- WAIT: one cycle covering the source read latency; go to CAP.
- CAP: tx_data<=dmp_din, tx_valid<=1, go to SEND.
- SEND: hold tx_data and tx_valid stable while tx_ready=0. On a handshake edge:
  - tx_valid<=0.
  - If ptr==LAST, go to FIN (or CHK).
  - Otherwise ptr<=ptr+1 (8-bit) and go to WAIT.
- FIN: done=1 for exactly this one cycle, busy<=0, ptr<=START, then IDLE.
- Throughput with tx_ready held high: 3 cycles per byte.
  - First tx_valid rises 2 edges after the start edge.
  - Default window: 80 bytes; done is high on cycle 241 counted from the start edge.
- Address arithmetic wraps modulo 256.
  - Bytes per dump = ((LAST-START) mod 256)+1.
  - LAST==START gives 1 byte; LAST==START-1 gives 256 bytes.
- start is ignored in every state other than IDLE. No queuing.
- abort has priority over all transitions in any non-IDLE state:
  - Next state is IDLE, tx_valid<=0, busy<=0, ptr<=START.
  - done is not pulsed.
  - A byte that has not been handshaked is dropped; the sink treats the stream as truncated.
- abort and tx_ready in the same SEND cycle: abort wins, but that byte counts as accepted by the sink.
- start and abort together in IDLE: start is ignored.
- rst mid-dump: immediate return to reset values. There is no partial output after rst.

Optional Feature:
Macro JT900H_DUMP_CHKSUM_EN.
- With the macro:
  - Accumulator sum<=sum+tx_data on every data-byte handshake; cleared on start, abort and rst.
  - After the LAST byte's handshake, go to CHK: tx_data<=8'h00-sum, tx_valid<=1.
  - On the CHK handshake go to FIN.
  - All bytes in the stream sum to 0 mod 256. Total bytes = window+1.
  - abort applies in CHK as in SEND.
- Without the macro: no CHK state and no accumulator; SEND goes straight to FIN.

Test Plan:
- Source model is a registered memory with mem[a]=a^8'h5A, and tx_ready=1 throughout. Pulse start.
  - Required: 80 bytes 0x5A,0x5B,...,0x15 (0x4F^0x5A) in order, one every 3 cycles.
  - done pulses once on cycle 241; busy is low afterwards.
- Backpressure: hold tx_ready=0 for 5 cycles while byte 3 (addr 0x03, 0x59) is valid.
  - Required: tx_data stays 0x59 and tx_valid stays high for 5 cycles.
  - Required: dmp_addr stays at 0x03 and there is no loss or duplication.
- Pulse start again at byte 10 of a dump.
  - Required: the stream is unaffected and still 80 bytes with a single done pulse.
- Assert abort for 1 cycle during SEND of byte 20 with tx_ready=0.
  - Required: tx_valid=0 and busy=0 on the next cycle, with no done pulse.
  - Required: a following start produces a full fresh dump from 0x00.
- Assert rst for 1 cycle in WAIT mid-dump.
  - Required: all outputs return to reset values at once, with dmp_addr=0x00.
- With JT900H_DUMP_CHKSUM_EN and mem all 0x01: 80 bytes of 0x01, then a checksum byte 0xB0.
  - Required: done one cycle after the checksum handshake.
  - Run with START=8'hFE, LAST=8'h01: addresses FE,FF,00,01, i.e. 4 data bytes.
